// File: rtl/reservation_station.sv
// Reservation station for non-load/store ops: buffers dispatched entries, snoops
// both CDBs for pending operands and issues the lowest-index ready entry to the ALU.
module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 4,
  parameter int OPENUM_W = 6,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [OPENUM_W-1:0] openum_from_dsp,
  input  logic [XLEN-1:0]     V1_from_dsp,
  input  logic [XLEN-1:0]     V2_from_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  input  logic [XLEN-1:0]     pc_from_dsp,
  input  logic [XLEN-1:0]     imm_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  input  logic                valid_from_Arith_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_Arith_unit_cdb,
  input  logic [XLEN-1:0]     result_from_Arith_unit_cdb,
  input  logic                valid_from_LS_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_LS_unit_cdb,
  input  logic [XLEN-1:0]     result_from_LS_unit_cdb,
  input  logic                misbranch_flag,
  output logic                full_to_if,
  output logic                valid_to_alu,
  output logic [OPENUM_W-1:0] openum_to_alu,
  output logic [XLEN-1:0]     V1_to_alu,
  output logic [XLEN-1:0]     V2_to_alu,
  output logic [XLEN-1:0]     imm_to_alu,
  output logic [XLEN-1:0]     pc_to_alu,
  output logic [ROB_ID_W-1:0] rob_id_to_alu
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam int QV_W  = ROB_ID_W + XLEN;

  logic [RS_SIZE-1:0]  r_busy;
  logic [OPENUM_W-1:0] r_op  [RS_SIZE];
  logic [XLEN-1:0]     r_v1  [RS_SIZE];
  logic [XLEN-1:0]     r_v2  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q1  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q2  [RS_SIZE];
  logic [XLEN-1:0]     r_pc  [RS_SIZE];
  logic [XLEN-1:0]     r_imm [RS_SIZE];
  logic [ROB_ID_W-1:0] r_rob [RS_SIZE];

  logic                r_valid;
  logic                r_full;
  logic [OPENUM_W-1:0] r_out_op;
  logic [XLEN-1:0]     r_out_v1;
  logic [XLEN-1:0]     r_out_v2;
  logic [XLEN-1:0]     r_out_imm;
  logic [XLEN-1:0]     r_out_pc;
  logic [ROB_ID_W-1:0] r_out_rob;

  logic                w_has_free;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_has_ready;
  logic [IDX_W-1:0]    w_issue_idx;
  logic                w_alloc;
  logic [CNT_W-1:0]    w_busy_cnt;
  logic [CNT_W-1:0]    w_next_cnt;
  logic                w_next_full;
  logic [RS_SIZE-1:0]  w_issue_mask;
  logic [RS_SIZE-1:0]  w_alloc_mask;
  logic [QV_W-1:0]     w_dsp_op1;
  logic [QV_W-1:0]     w_dsp_op2;
  logic [QV_W-1:0]     w_wake1 [RS_SIZE];
  logic [QV_W-1:0]     w_wake2 [RS_SIZE];

  // Returns {tag, value}; a nonzero tag hit on a CDB becomes {0, broadcast value}.
  function automatic logic [QV_W-1:0] snoop(
    input logic [ROB_ID_W-1:0] q,
    input logic [XLEN-1:0]     v,
    input logic                a_vld,
    input logic [ROB_ID_W-1:0] a_tag,
    input logic [XLEN-1:0]     a_val,
    input logic                l_vld,
    input logic [ROB_ID_W-1:0] l_tag,
    input logic [XLEN-1:0]     l_val
  );
    logic [QV_W-1:0] res;
    res = {q, v};
    if (q != '0) begin
      if (a_vld && q == a_tag) begin
        res = {{ROB_ID_W{1'b0}}, a_val};
      end else if (l_vld && q == l_tag) begin
        res = {{ROB_ID_W{1'b0}}, l_val};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    w_has_ready = 1'b0;
    w_issue_idx = '0;
    w_busy_cnt  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_busy[i] && r_q1[i] == '0 && r_q2[i] == '0) begin
        w_has_ready = 1'b1;
        w_issue_idx = IDX_W'(i);
      end
      w_busy_cnt = w_busy_cnt + CNT_W'(r_busy[i]);
    end
  end

  // Occupancy after the edge; full keeps one slot of slack for the dispatcher pipeline.
  always_comb begin
    w_alloc      = ena_from_dsp && (openum_from_dsp != '0) && w_has_free;
    w_issue_mask = w_has_ready ? (RS_SIZE'(1) << w_issue_idx) : '0;
    w_alloc_mask = w_alloc ? (RS_SIZE'(1) << w_free_idx) : '0;
    w_next_cnt   = w_busy_cnt + CNT_W'(w_alloc) - CNT_W'(w_has_ready);
    w_next_full  = (CNT_W'(RS_SIZE) - w_next_cnt) <= CNT_W'(1);
  end

  always_comb begin
    w_dsp_op1 = snoop(Q1_from_dsp, V1_from_dsp,
                      valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
                      valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb);
    w_dsp_op2 = snoop(Q2_from_dsp, V2_from_dsp,
                      valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
                      valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb);
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wake1[i] = snoop(r_q1[i], r_v1[i],
                         valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
                         valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb);
      w_wake2[i] = snoop(r_q2[i], r_v2[i],
                         valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
                         valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb);
    end
  end

  // Entry payloads need no reset: an entry is only meaningful while its busy bit is set.
  always_ff @(posedge clk) begin
    if (rdy && !misbranch_flag) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_alloc_mask[i]) begin
          r_op[i]  <= openum_from_dsp;
          r_pc[i]  <= pc_from_dsp;
          r_imm[i] <= imm_from_dsp;
          r_rob[i] <= rob_id_from_dsp;
          r_q1[i]  <= w_dsp_op1[QV_W-1:XLEN];
          r_v1[i]  <= w_dsp_op1[XLEN-1:0];
          r_q2[i]  <= w_dsp_op2[QV_W-1:XLEN];
          r_v2[i]  <= w_dsp_op2[XLEN-1:0];
        end else if (r_busy[i]) begin
          r_q1[i]  <= w_wake1[i][QV_W-1:XLEN];
          r_v1[i]  <= w_wake1[i][XLEN-1:0];
          r_q2[i]  <= w_wake2[i][QV_W-1:XLEN];
          r_v2[i]  <= w_wake2[i][XLEN-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= '0;
      r_valid   <= 1'b0;
      r_full    <= 1'b0;
      r_out_op  <= '0;
      r_out_v1  <= '0;
      r_out_v2  <= '0;
      r_out_imm <= '0;
      r_out_pc  <= '0;
      r_out_rob <= '0;
    end else if (rdy) begin
      if (misbranch_flag) begin
        r_busy  <= '0;
        r_valid <= 1'b0;
        r_full  <= 1'b0;
      end else begin
        r_busy  <= (r_busy & ~w_issue_mask) | w_alloc_mask;
        r_valid <= w_has_ready;
        r_full  <= w_next_full;
        if (w_has_ready) begin
          r_out_op  <= r_op[w_issue_idx];
          r_out_v1  <= r_v1[w_issue_idx];
          r_out_v2  <= r_v2[w_issue_idx];
          r_out_imm <= r_imm[w_issue_idx];
          r_out_pc  <= r_pc[w_issue_idx];
          r_out_rob <= r_rob[w_issue_idx];
        end
      end
    end
  end

  assign full_to_if    = r_full;
  assign valid_to_alu  = r_valid;
  assign openum_to_alu = r_out_op;
  assign V1_to_alu     = r_out_v1;
  assign V2_to_alu     = r_out_v2;
  assign imm_to_alu    = r_out_imm;
  assign pc_to_alu     = r_out_pc;
  assign rob_id_to_alu = r_out_rob;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: an entry-table model predicts the ALU/full
// outputs every cycle, and hand-computed literals pin the key scenarios.
module tb_reservation_station;

  localparam int RS = 16;
  localparam int RW = 4;
  localparam int OW = 6;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          ena = 1'b0;
  logic [OW-1:0] opIn = '0;
  logic [XL-1:0] v1In = '0;
  logic [XL-1:0] v2In = '0;
  logic [RW-1:0] q1In = '0;
  logic [RW-1:0] q2In = '0;
  logic [XL-1:0] pcIn = '0;
  logic [XL-1:0] immIn = '0;
  logic [RW-1:0] robIn = '0;
  logic          arithValid = 1'b0;
  logic [RW-1:0] arithTag = '0;
  logic [XL-1:0] arithData = '0;
  logic          lsValid = 1'b0;
  logic [RW-1:0] lsTag = '0;
  logic [XL-1:0] lsData = '0;
  logic          misbranch = 1'b0;

  logic          fullOut;
  logic          validOut;
  logic [OW-1:0] opOut;
  logic [XL-1:0] v1Out;
  logic [XL-1:0] v2Out;
  logic [XL-1:0] immOut;
  logic [XL-1:0] pcOut;
  logic [RW-1:0] robOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(RS), .ROB_ID_W(RW), .OPENUM_W(OW), .XLEN(XL)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .ena_from_dsp               (ena),
    .openum_from_dsp            (opIn),
    .V1_from_dsp                (v1In),
    .V2_from_dsp                (v2In),
    .Q1_from_dsp                (q1In),
    .Q2_from_dsp                (q2In),
    .pc_from_dsp                (pcIn),
    .imm_from_dsp               (immIn),
    .rob_id_from_dsp            (robIn),
    .valid_from_Arith_unit_cdb  (arithValid),
    .rob_id_from_Arith_unit_cdb (arithTag),
    .result_from_Arith_unit_cdb (arithData),
    .valid_from_LS_unit_cdb     (lsValid),
    .rob_id_from_LS_unit_cdb    (lsTag),
    .result_from_LS_unit_cdb    (lsData),
    .misbranch_flag             (misbranch),
    .full_to_if                 (fullOut),
    .valid_to_alu               (validOut),
    .openum_to_alu              (opOut),
    .V1_to_alu                  (v1Out),
    .V2_to_alu                  (v2Out),
    .imm_to_alu                 (immOut),
    .pc_to_alu                  (pcOut),
    .rob_id_to_alu              (robOut)
  );

  typedef struct packed {
    logic          busy;
    logic [OW-1:0] op;
    logic [XL-1:0] v1;
    logic [XL-1:0] v2;
    logic [RW-1:0] q1;
    logic [RW-1:0] q2;
    logic [XL-1:0] pc;
    logic [XL-1:0] imm;
    logic [RW-1:0] rob;
  } entry_t;

  entry_t mEnt [RS];
  entry_t nEnt [RS];
  entry_t mOut;
  entry_t nOut;
  entry_t newEnt;
  logic   mValid, nValid, mFull, nFull, mProtoHit, protoViol;
  int     issueIdx, freeIdx, freeCnt;

  // Resolve any waiting operand of an entry against the two broadcasts, arith first.
  function automatic entry_t resolve(input entry_t e);
    entry_t r;
    r = e;
    if (r.q1 != 0) begin
      if (arithValid && r.q1 == arithTag) begin r.v1 = arithData; r.q1 = 0; end
      else if (lsValid && r.q1 == lsTag) begin r.v1 = lsData; r.q1 = 0; end
    end
    if (r.q2 != 0) begin
      if (arithValid && r.q2 == arithTag) begin r.v2 = arithData; r.q2 = 0; end
      else if (lsValid && r.q2 == lsTag) begin r.v2 = lsData; r.q2 = 0; end
    end
    return r;
  endfunction

  // Next model state: pick the oldest-index ready slot, wake waiters, place the new op.
  always_comb begin
    nEnt      = mEnt;
    nOut      = mOut;
    nValid    = mValid;
    nFull     = mFull;
    protoViol = 1'b0;
    issueIdx  = -1;
    freeIdx   = -1;
    freeCnt   = 0;
    newEnt    = '0;
    if (rdy) begin
      if (misbranch) begin
        for (int i = 0; i < RS; i++) nEnt[i].busy = 1'b0;
        nValid = 1'b0;
        nFull  = 1'b0;
      end else begin
        for (int i = 0; i < RS; i++) begin
          if (issueIdx < 0 && mEnt[i].busy && mEnt[i].q1 == 0 && mEnt[i].q2 == 0) issueIdx = i;
          if (freeIdx < 0 && !mEnt[i].busy) freeIdx = i;
          if (mEnt[i].busy) nEnt[i] = resolve(mEnt[i]);
        end
        nValid = (issueIdx >= 0);
        if (issueIdx >= 0) begin
          nOut = mEnt[issueIdx];
          nEnt[issueIdx].busy = 1'b0;
        end
        if (ena && opIn != 0) begin
          if (freeIdx >= 0) begin
            newEnt = '{busy: 1'b1, op: opIn, v1: v1In, v2: v2In, q1: q1In, q2: q2In,
                       pc: pcIn, imm: immIn, rob: robIn};
            nEnt[freeIdx] = resolve(newEnt);
          end else begin
            protoViol = 1'b1;
          end
        end
        for (int i = 0; i < RS; i++) if (!nEnt[i].busy) freeCnt++;
        nFull = (freeCnt <= 1);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS; i++) mEnt[i] <= '0;
      mOut      <= '0;
      mValid    <= 1'b0;
      mFull     <= 1'b0;
      mProtoHit <= 1'b0;
    end else begin
      mEnt      <= nEnt;
      mOut      <= nOut;
      mValid    <= nValid;
      mFull     <= nFull;
      mProtoHit <= rdy && !misbranch && protoViol;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    checkOutput("model valid_to_alu", 32'(validOut), 32'(mValid));
    checkOutput("model full_to_if", 32'(fullOut), 32'(mFull));
    checkOutput("dispatch into full station", 32'(mProtoHit), 32'd0);
    if (mValid) begin
      checkOutput("model openum_to_alu", 32'(opOut), 32'(mOut.op));
      checkOutput("model V1_to_alu", v1Out, mOut.v1);
      checkOutput("model V2_to_alu", v2Out, mOut.v2);
      checkOutput("model imm_to_alu", immOut, mOut.imm);
      checkOutput("model pc_to_alu", pcOut, mOut.pc);
      checkOutput("model rob_id_to_alu", 32'(robOut), 32'(mOut.rob));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [OW-1:0] o, input logic [XL-1:0] a,
                               input logic [XL-1:0] b, input logic [RW-1:0] qa,
                               input logic [RW-1:0] qb, input logic [RW-1:0] r);
    ena   = e;
    opIn  = o;
    v1In  = a;
    v2In  = b;
    q1In  = qa;
    q2In  = qb;
    robIn = r;
    pcIn  = 32'h1000 + {26'd0, r, 2'b00};
    immIn = {28'd0, r} + 32'h100;
  endtask

  task automatic setCdb(input logic av, input logic [RW-1:0] at, input logic [XL-1:0] ad,
                        input logic lv, input logic [RW-1:0] lt, input logic [XL-1:0] ld);
    arithValid = av;
    arithTag   = at;
    arithData  = ad;
    lsValid    = lv;
    lsTag      = lt;
    lsData     = ld;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
    setCdb(1'b0, '0, '0, 1'b0, '0, '0);
    misbranch = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #11;
    checkOutput("reset valid_to_alu", 32'(validOut), 32'd0);
    checkOutput("reset full_to_if", 32'(fullOut), 32'd0);
    checkOutput("reset rob_id_to_alu", 32'(robOut), 32'd0);
    rst = 1'b1;

    // Ready operands: written at edge 1, issued at edge 2.
    applyStimulus(1'b1, 6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
    tick();
    idle();
    checkOutput("add no bypass", 32'(validOut), 32'd0);
    tick();
    checkOutput("add valid", 32'(validOut), 32'd1);
    checkOutput("add V1", v1Out, 32'd5);
    checkOutput("add V2", v2Out, 32'd7);
    checkOutput("add rob", 32'(robOut), 32'd3);
    checkOutput("add pc", pcOut, 32'h100C);
    tick();
    checkOutput("add single issue", 32'(validOut), 32'd0);

    // Arith CDB wakes operand 1 two cycles after dispatch.
    applyStimulus(1'b1, 6'd2, 32'd0, 32'd11, 4'd2, 4'd0, 4'd5);
    tick();
    idle();
    tick();
    setCdb(1'b1, 4'd2, 32'h1234, 1'b0, '0, '0);
    tick();
    idle();
    checkOutput("wake not yet issued", 32'(validOut), 32'd0);
    tick();
    checkOutput("wake valid", 32'(validOut), 32'd1);
    checkOutput("wake V1", v1Out, 32'h1234);
    checkOutput("wake V2", v2Out, 32'd11);
    checkOutput("wake rob", 32'(robOut), 32'd5);
    tick();

    // LS broadcast forwarded into the entry being allocated.
    applyStimulus(1'b1, 6'd4, 32'd1, 32'd0, 4'd0, 4'd4, 4'd6);
    setCdb(1'b0, '0, '0, 1'b1, 4'd4, 32'd9);
    tick();
    idle();
    tick();
    checkOutput("forward valid", 32'(validOut), 32'd1);
    checkOutput("forward V2", v2Out, 32'd9);
    checkOutput("forward rob", 32'(robOut), 32'd6);
    tick();

    // Fill fifteen waiting entries, then release them all with one broadcast.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 6'd3, 32'(i), 32'(i * 2), 4'd6, 4'd0, 4'(i + 1));
      tick();
      if (i == 13) checkOutput("fill 14 not full", 32'(fullOut), 32'd0);
      if (i == 14) checkOutput("fill 15 full", 32'(fullOut), 32'd1);
    end
    idle();
    setCdb(1'b1, 4'd6, 32'hABC, 1'b0, '0, '0);
    tick();
    idle();
    checkOutput("fill wake no issue", 32'(validOut), 32'd0);
    checkOutput("fill still full", 32'(fullOut), 32'd1);
    tick();
    checkOutput("drain first valid", 32'(validOut), 32'd1);
    checkOutput("drain first rob", 32'(robOut), 32'd1);
    checkOutput("drain first V1", v1Out, 32'hABC);
    checkOutput("drain first V2", v2Out, 32'd0);
    checkOutput("drain full drops", 32'(fullOut), 32'd0);
    for (int k = 2; k <= 15; k++) begin
      tick();
      checkOutput("drain order rob", 32'(robOut), 32'(k));
      checkOutput("drain order V2", v2Out, 32'((k - 1) * 2));
    end
    tick();
    checkOutput("drain done", 32'(validOut), 32'd0);

    // Misbranch flushes resident entries and drops the concurrent dispatch.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 6'd5, 32'(i), 32'd0, 4'd7, 4'd0, 4'(i));
      tick();
    end
    applyStimulus(1'b1, 6'd5, 32'd40, 32'd41, 4'd0, 4'd0, 4'd4);
    misbranch = 1'b1;
    tick();
    idle();
    checkOutput("flush valid", 32'(validOut), 32'd0);
    checkOutput("flush full", 32'(fullOut), 32'd0);
    tick();
    checkOutput("flush drops dispatch", 32'(validOut), 32'd0);
    setCdb(1'b1, 4'd7, 32'd77, 1'b0, '0, '0);
    tick();
    idle();
    tick();
    checkOutput("flush no late issue", 32'(validOut), 32'd0);

    // Pause while an issue is on the outputs and the CDB is active.
    applyStimulus(1'b1, 6'd1, 32'h80, 32'h81, 4'd0, 4'd0, 4'd8);
    tick();
    applyStimulus(1'b1, 6'd1, 32'd0, 32'h91, 4'd9, 4'd0, 4'd9);
    tick();
    idle();
    checkOutput("pre-pause valid", 32'(validOut), 32'd1);
    rdy = 1'b0;
    setCdb(1'b1, 4'd9, 32'h55, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("pause holds valid", 32'(validOut), 32'd1);
      checkOutput("pause holds rob", 32'(robOut), 32'd8);
    end
    rdy = 1'b1;
    idle();
    tick();
    checkOutput("resume clears valid", 32'(validOut), 32'd0);
    tick();
    checkOutput("pause ignored cdb", 32'(validOut), 32'd0);
    setCdb(1'b1, 4'd9, 32'h66, 1'b0, '0, '0);
    tick();
    idle();
    tick();
    checkOutput("resume wake valid", 32'(validOut), 32'd1);
    checkOutput("resume wake V1", v1Out, 32'h66);
    checkOutput("resume wake rob", 32'(robOut), 32'd9);
    tick();

    // NOP dispatch is dropped.
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd2, 4'd0, 4'd0, 4'd10);
    tick();
    idle();
    tick();
    checkOutput("nop dropped", 32'(validOut), 32'd0);

    // Asynchronous reset mid-run clears outputs between edges.
    applyStimulus(1'b1, 6'd1, 32'hC0, 32'hC1, 4'd0, 4'd0, 4'd11);
    tick();
    idle();
    tick();
    checkOutput("pre-reset valid", 32'(validOut), 32'd1);
    checkOutput("pre-reset rob", 32'(robOut), 32'd11);
    rst = 1'b0;
    #1;
    checkOutput("async reset valid", 32'(validOut), 32'd0);
    checkOutput("async reset full", 32'(fullOut), 32'd0);
    checkOutput("async reset rob", 32'(robOut), 32'd0);
    checkOutput("async reset V1", v1Out, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("post-reset idle", 32'(validOut), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher→RS interface for all non-load/store instructions.
- Buffers up to RS_SIZE entries and snoops both CDBs (arith, LS) to resolve pending operands.
- Issues one operand-ready entry per cycle to the arithmetic unit.
- Drives a registered full flag back to the fetcher; flushes completely on misbranch.

Parameters:
RS_SIZE, 16, number of entries (power of 2, ≥4)
ROB_ID_W, 4, ROB tag width; tag 0 means "no dependency / value valid"
OPENUM_W, 6, opcode-enum width; enum value 0 is NOP
XLEN, 32, data/address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
rdy  in  1  global run enable; low = pause
ena_from_dsp  in  1  dispatch valid
openum_from_dsp  in  OPENUM_W  operation enum
V1_from_dsp  in  XLEN  operand 1 value (meaningful when Q1=0)
V2_from_dsp  in  XLEN  operand 2 value
Q1_from_dsp  in  ROB_ID_W  operand 1 producer tag
Q2_from_dsp  in  ROB_ID_W  operand 2 producer tag
pc_from_dsp  in  XLEN  instruction PC
imm_from_dsp  in  XLEN  immediate
rob_id_from_dsp  in  ROB_ID_W  destination ROB tag
valid_from_Arith_unit_cdb  in  1  arith CDB broadcast valid
rob_id_from_Arith_unit_cdb  in  ROB_ID_W  arith CDB tag
result_from_Arith_unit_cdb  in  XLEN  arith CDB value
valid_from_LS_unit_cdb  in  1  LS CDB broadcast valid
rob_id_from_LS_unit_cdb  in  ROB_ID_W  LS CDB tag
result_from_LS_unit_cdb  in  XLEN  LS CDB value
misbranch_flag  in  1  flush request
full_to_if  out  1  stall fetch/dispatch
valid_to_alu  out  1  issue valid
openum_to_alu  out  OPENUM_W  issued op
V1_to_alu  out  XLEN  issued operand 1
V2_to_alu  out  XLEN  issued operand 2
imm_to_alu  out  XLEN  issued immediate
pc_to_alu  out  XLEN  issued PC
rob_id_to_alu  out  ROB_ID_W  issued destination tag

Behaviour:
- Reset (rst=0, async): every busy bit, valid_to_alu and full_to_if cleared to 0; all other outputs cleared to 0. Entry payloads are don't-care.
- Priority per edge: reset > rdy=0 > misbranch_flag > normal operation.
- rdy=0: all entry state and all outputs hold their values.
- misbranch_flag=1: all busy bits cleared, valid_to_alu←0, full_to_if←0. Dispatch and CDB inputs are ignored that cycle.
- Allocation: on ena_from_dsp=1 with a non-NOP openum, write the lowest-index non-busy entry, chosen from the pre-edge busy map.
  - ena with NOP is dropped.
  - ena while no entry is free is a protocol violation: the input is dropped, existing state is unchanged, and the bench flags it.
- Same-cycle forwarding at allocation: if Qn≠0 and matches a valid CDB tag, store that CDB value and set Qn=0.
  - Arith CDB has priority over LS CDB on a tag match (the two should never carry the same tag).
- Wakeup: each busy entry with Qn≠0 that matches a valid CDB tag captures the value and clears Qn at the edge.
- Issue select: the lowest-index entry that is busy with Q1=0 and Q2=0 in the pre-edge state.
  - Its fields are registered onto the *_to_alu outputs, valid_to_alu←1, and the entry's busy bit clears.
  - If no entry is ready, valid_to_alu←0.
  - At most one issue per cycle.
- Latency:
  - Operands ready at dispatch: entry written at edge k, valid_to_alu high after edge k+1.
  - Entry woken by CDB at edge k: issues at edge k+1.
  - No combinational bypass from the dispatch inputs to the ALU outputs.
- Simultaneous alloc and issue in one cycle: both are performed. The issued slot becomes free only after the edge and cannot be reused in that same cycle.
- full_to_if (registered): 1 when the post-edge free-entry count ≤ 1. This margin covers the one-cycle dispatcher pipeline.
- Tag 0 is never matched against the CDBs; an entry with Qn=0 ignores CDB traffic.

Test Plan:
- Reset, then dispatch ADD with Q1=Q2=0, V1=5, V2=7, rob_id=3 at edge 1 -> valid_to_alu=1 after edge 2 with V1=5, V2=7, rob_id=3; after edge 3 valid_to_alu=0.
- Dispatch with Q1=2; arith CDB broadcasts tag 2, value 0x1234 two cycles later -> issue on the edge after the broadcast with V1=0x1234.
- Dispatch Q2=4 in the same cycle the LS CDB broadcasts tag 4, value 9 -> entry stored ready; issue after next edge with V2=9.
- Fill 15 entries with Q1=6, no CDB traffic -> full_to_if=1 once free count ≤ 1. Then arith CDB tag 6 -> issues in ascending index order, one per cycle, and full_to_if drops after the first issue.
- Three entries resident, misbranch_flag=1 with ena also high -> all cleared, valid_to_alu=0, the new dispatch is dropped, no issue afterwards.
- rdy=0 for 3 cycles while valid_to_alu=1 and the CDB is active -> outputs and entries frozen and the CDB is not captured; operation resumes once rdy=1. Also assert rst=0 mid-run -> outputs drop to 0 immediately, without waiting for a clock edge.
